// File: rtl/rate_meter.sv
// rate_meter: measures the spacing of single-cycle enable strobes on PulseIn,
// reports the raw interval (Period) and decodes it back into the 2-bit speed
// class of a rate divider (00 = every cycle, 01 = 1 s, 10 = 2 s, 11 = 4 s).
// A class k matches when |P - Nk| <= Nk >> TOL_SHIFT; class 0 needs P == 1.
//
// Optional feature: define RATE_METER_MINMAX_EN to add MinPeriod/MaxPeriod
// outputs tracking the extremes of every reported interval.
module rate_meter #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int CNT_W           = 29,
  parameter int TOL_SHIFT       = 3
) (
  input  logic             ClockIn,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             PulseIn,
  output logic [CNT_W-1:0] Period,
  output logic [1:0]       SpeedCode,
  output logic             Valid,
  output logic             Mismatch,
  output logic             Locked,
  output logic             Timeout
`ifdef RATE_METER_MINMAX_EN
  ,
  output logic [CNT_W-1:0] MinPeriod,
  output logic [CNT_W-1:0] MaxPeriod
`endif
);

  // Comparisons are done one bit wider than the counter so that Nk + tol
  // can never wrap, whatever the parameters.
  localparam int W1 = CNT_W + 1;

  localparam logic [W1-1:0] NOM_4S = W1'(4 * CLOCK_FREQUENCY);
  localparam logic [W1-1:0] LIMIT  = NOM_4S + (NOM_4S >> TOL_SHIFT) + W1'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [1:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             mismatch_q, mismatch_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  // Set once an interval has matched a class since the last reset/Clear/timeout;
  // code_q then holds that previous matched class for the Locked comparison.
  logic             have_prev_q, have_prev_d;

  logic [W1-1:0]    p_ext;
  logic [3:0]       hit;
  logic             match;
  logic [1:0]       match_code;
  logic             rec_evt;
  logic             to_evt;

  assign p_ext = {1'b0, cnt_q};

  // An event while running closes an interval; running out to LIMIT with no
  // event is a timeout. Clear suppresses both.
  assign rec_evt = !Clear && (state_q == S_RUN) && PulseIn;
  assign to_evt  = !Clear && (state_q == S_RUN) && !PulseIn && (p_ext == LIMIT);

  // Class 0 is an exact match on a one-cycle interval.
  assign hit[0] = (p_ext == W1'(1));

  // Classes 1..3 have nominal F, 2F, 4F with a window of +/- Nk>>TOL_SHIFT.
  for (genvar gi = 1; gi < 4; gi++) begin : g_class
    localparam logic [W1-1:0] NOM = W1'(CLOCK_FREQUENCY) << (gi - 1);
    localparam logic [W1-1:0] TOL = NOM >> TOL_SHIFT;
    localparam logic [W1-1:0] LO  = NOM - TOL;
    localparam logic [W1-1:0] HI  = NOM + TOL;
    assign hit[gi] = (p_ext >= LO) && (p_ext <= HI);
  end

  // Priority-encode the class hits; lowest class wins.
  always_comb begin
    match      = 1'b1;
    match_code = 2'd0;
    if (hit[0]) begin
      match_code = 2'd0;
    end else if (hit[1]) begin
      match_code = 2'd1;
    end else if (hit[2]) begin
      match_code = 2'd2;
    end else if (hit[3]) begin
      match_code = 2'd3;
    end else begin
      match = 1'b0;
    end
  end

  // Next-state logic: interval counter, IDLE/RUN control and result registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    code_d      = code_q;
    valid_d     = 1'b0;
    mismatch_d  = mismatch_q;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    have_prev_d = have_prev_q;

    if (Clear) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      period_d    = '0;
      code_d      = 2'd0;
      mismatch_d  = 1'b0;
      locked_d    = 1'b0;
      timeout_d   = 1'b0;
      have_prev_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // The first event only starts timing; there is no interval yet.
          cnt_d = '0;
          if (PulseIn) begin
            cnt_d     = CNT_W'(1);
            state_d   = S_RUN;
            timeout_d = 1'b0;
          end
        end
        S_RUN: begin
          if (rec_evt) begin
            // The count before reload is the interval in cycles.
            cnt_d    = CNT_W'(1);
            valid_d  = 1'b1;
            period_d = cnt_q;
            if (match) begin
              code_d      = match_code;
              mismatch_d  = 1'b0;
              locked_d    = have_prev_q && (match_code == code_q);
              have_prev_d = 1'b1;
            end else begin
              mismatch_d = 1'b1;
              locked_d   = 1'b0;
            end
          end else if (to_evt) begin
            // Period/SpeedCode keep the last result; the next event restarts.
            timeout_d   = 1'b1;
            locked_d    = 1'b0;
            have_prev_d = 1'b0;
            cnt_d       = '0;
            state_d     = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and result registers with asynchronous active-low reset.
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      code_q      <= 2'd0;
      valid_q     <= 1'b0;
      mismatch_q  <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      mismatch_q  <= mismatch_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign Period    = period_q;
  assign SpeedCode = code_q;
  assign Valid     = valid_q;
  assign Mismatch  = mismatch_q;
  assign Locked    = locked_q;
  assign Timeout   = timeout_q;

`ifdef RATE_METER_MINMAX_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
  // Cleared on reset/Clear/timeout so the next interval loads both extremes.
  logic             seen_q, seen_d;

  // Track extremes over every reported interval, mismatches included.
  always_comb begin
    min_d  = min_q;
    max_d  = max_q;
    seen_d = seen_q;
    if (Clear) begin
      min_d  = '1;
      max_d  = '0;
      seen_d = 1'b0;
    end else if (rec_evt) begin
      seen_d = 1'b1;
      if (!seen_q) begin
        min_d = cnt_q;
        max_d = cnt_q;
      end else begin
        if (cnt_q < min_q) min_d = cnt_q;
        if (cnt_q > max_q) max_d = cnt_q;
      end
    end else if (to_evt) begin
      seen_d = 1'b0;
    end
  end

  // Min/max registers; reset leaves Min at all-ones and Max at zero.
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      min_q  <= '1;
      max_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      min_q  <= min_d;
      max_q  <= max_d;
      seen_q <= seen_d;
    end
  end

  assign MinPeriod = min_q;
  assign MaxPeriod = max_q;
`endif

endmodule

// File: tb/tb_rate_meter.sv
// tb_rate_meter: directed test of rate_meter with CLOCK_FREQUENCY=16,
// TOL_SHIFT=3 (classes: 1, 14..18, 28..36, 56..72; LIMIT=73).
// Define RATE_METER_MINMAX_EN to also cover MinPeriod/MaxPeriod.
module tb_rate_meter;

  localparam int F     = 16;
  localparam int CNT_W = 29;
  localparam int TOLS  = 3;

  logic             ClockIn;
  logic             Reset;
  logic             Clear;
  logic             PulseIn;
  logic [CNT_W-1:0] Period;
  logic [1:0]       SpeedCode;
  logic             Valid;
  logic             Mismatch;
  logic             Locked;
  logic             Timeout;
`ifdef RATE_METER_MINMAX_EN
  logic [CNT_W-1:0] MinPeriod;
  logic [CNT_W-1:0] MaxPeriod;
`endif

  int n_checks = 0;
  int n_errors = 0;

  rate_meter #(
    .CLOCK_FREQUENCY(F),
    .CNT_W          (CNT_W),
    .TOL_SHIFT      (TOLS)
  ) dut (
    .ClockIn  (ClockIn),
    .Reset    (Reset),
    .Clear    (Clear),
    .PulseIn  (PulseIn),
    .Period   (Period),
    .SpeedCode(SpeedCode),
    .Valid    (Valid),
    .Mismatch (Mismatch),
    .Locked   (Locked),
    .Timeout  (Timeout)
`ifdef RATE_METER_MINMAX_EN
    ,
    .MinPeriod(MinPeriod),
    .MaxPeriod(MaxPeriod)
`endif
  );

  initial ClockIn = 1'b0;
  always #5 ClockIn = ~ClockIn;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge ClockIn);
    #1;
  endtask

  // One-cycle strobe; outputs for that event are visible on return.
  task automatic pulse();
    PulseIn = 1'b1;
    step();
    PulseIn = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) step();
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    step();
    Clear = 1'b0;
  endtask

  task automatic expect_rec(input string tag, input int per, input int code,
                            input bit mism, input bit lock);
    check({tag, ".valid"}, 64'(Valid), 64'd1);
    check({tag, ".period"}, 64'(Period), 64'(per));
    check({tag, ".code"}, 64'(SpeedCode), 64'(code));
    check({tag, ".mismatch"}, 64'(Mismatch), 64'(mism));
    check({tag, ".locked"}, 64'(Locked), 64'(lock));
  endtask

  task automatic expect_zero(input string tag);
    check({tag, ".valid"}, 64'(Valid), 64'd0);
    check({tag, ".period"}, 64'(Period), 64'd0);
    check({tag, ".code"}, 64'(SpeedCode), 64'd0);
    check({tag, ".mismatch"}, 64'(Mismatch), 64'd0);
    check({tag, ".locked"}, 64'(Locked), 64'd0);
    check({tag, ".timeout"}, 64'(Timeout), 64'd0);
  endtask

  initial begin
    Reset   = 1'b0;
    Clear   = 1'b0;
    PulseIn = 1'b0;
    gap(3);
    expect_zero("reset");
`ifdef RATE_METER_MINMAX_EN
    check("reset.min", 64'(MinPeriod), 64'h1FFF_FFFF);
    check("reset.max", 64'(MaxPeriod), 64'd0);
`endif
    Reset = 1'b1;
    gap(2);

    // PulseIn held high: interval 1 every cycle after the first event.
    PulseIn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) begin
        check("hold.first.valid", 64'(Valid), 64'd0);
      end else begin
        expect_rec($sformatf("hold%0d", i), 1, 0, 1'b0, i >= 3);
      end
    end
    PulseIn = 1'b0;
    step();
    check("hold.end.valid", 64'(Valid), 64'd0);

    // 1 s class: 16, 17, 14.
    do_clear();
    expect_zero("clear1");
    pulse();
    check("s1.first.valid", 64'(Valid), 64'd0);
    gap(15); pulse();
    expect_rec("s1.16", 16, 1, 1'b0, 1'b0);
    step();
    check("s1.valid.drop", 64'(Valid), 64'd0);
    gap(15); pulse();
    expect_rec("s1.17", 17, 1, 1'b0, 1'b1);
    gap(13); pulse();
    expect_rec("s1.14", 14, 1, 1'b0, 1'b1);

    // Tolerance edges: 18 matches class 1, 19 matches nothing.
    gap(17); pulse();
    expect_rec("tol.18", 18, 1, 1'b0, 1'b1);
    gap(18); pulse();
    expect_rec("tol.19", 19, 1, 1'b1, 1'b0);

    // 4 s class twice, then an unmatched 40.
    do_clear();
    pulse();
    gap(63); pulse();
    expect_rec("s4.64a", 64, 3, 1'b0, 1'b0);
    gap(63); pulse();
    expect_rec("s4.64b", 64, 3, 1'b0, 1'b1);
    gap(39); pulse();
    expect_rec("s4.40", 40, 3, 1'b1, 1'b0);

    // Timeout: nothing for 80 cycles after a strobe.
    do_clear();
    pulse();
    for (int i = 1; i <= 72; i++) begin
      step();
      if (Valid !== 1'b0) check($sformatf("to.novalid%0d", i), 64'(Valid), 64'd0);
    end
    check("to.before", 64'(Timeout), 64'd0);
    step();
    check("to.at73", 64'(Timeout), 64'd1);
    check("to.at73.valid", 64'(Valid), 64'd0);
    gap(7);
    check("to.hold", 64'(Timeout), 64'd1);
    check("to.period.hold", 64'(Period), 64'd0);
    pulse();
    check("to.clear", 64'(Timeout), 64'd0);
    check("to.restart.valid", 64'(Valid), 64'd0);
    gap(31); pulse();
    check("s2.32.valid", 64'(Valid), 64'd1);
    check("s2.32.period", 64'(Period), 64'd32);
    check("s2.32.code", 64'(SpeedCode), 64'd2);
    check("s2.32.mismatch", 64'(Mismatch), 64'd0);

    // Event exactly at counter == LIMIT: classified (mismatch), stays running.
    do_clear();
    pulse();
    gap(72); pulse();
    expect_rec("lim.73", 73, 0, 1'b1, 1'b0);
    check("lim.timeout", 64'(Timeout), 64'd0);
    gap(15); pulse();
    expect_rec("lim.then16", 16, 1, 1'b0, 1'b0);

    // Clear together with an event: Clear wins, next event is a first event.
    PulseIn = 1'b1;
    Clear   = 1'b1;
    step();
    Clear   = 1'b0;
    PulseIn = 1'b0;
    expect_zero("clrevt");
    pulse();
    check("clrevt.next.valid", 64'(Valid), 64'd0);

    // Asynchronous reset 20 cycles into a 32-cycle interval.
    gap(31); pulse();
    expect_rec("ar.32", 32, 2, 1'b0, 1'b0);
    gap(19);
    #2;
    Reset = 1'b0;
    #1;
    expect_zero("async");
    step();
    Reset = 1'b1;
    step();
    pulse();
    check("ar.first.valid", 64'(Valid), 64'd0);
    gap(15); pulse();
    expect_rec("ar.16", 16, 1, 1'b0, 1'b0);

`ifdef RATE_METER_MINMAX_EN
    // Min/max over 16, 30, 64, then Clear.
    do_clear();
    pulse();
    gap(15); pulse();
    gap(29); pulse();
    check("mm.30.code", 64'(SpeedCode), 64'd2);
    gap(63); pulse();
    check("mm.min", 64'(MinPeriod), 64'd16);
    check("mm.max", 64'(MaxPeriod), 64'd64);
    do_clear();
    check("mm.clr.min", 64'(MinPeriod), 64'h1FFF_FFFF);
    check("mm.clr.max", 64'(MaxPeriod), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rate_meter.md
Name: rate_meter

Overview:
- Measures the spacing of single-cycle enable strobes, such as those from a rate divider, on a pulse-train input.
- Decodes the measured interval back into the 2-bit speed code (00 = every cycle, 01 = 1 s, 10 = 2 s, 11 = 4 s) and reports the raw period.
- Used on the board to check a divider's output against the selected Speed, and to drive HEX/LED status.

Parameters:
CLOCK_FREQUENCY, 50000000, clock cycles per second; sets nominal intervals N0=1, N1=F, N2=2F, N3=4F
CNT_W, 29, width of interval counter and Period output; must hold 4F + (4F>>TOL_SHIFT) + 1
TOL_SHIFT, 3, match tolerance for class k is Nk>>TOL_SHIFT cycles (1/8 by default)

Ports:
ClockIn  input  1  system clock, all logic on rising edge
Reset  input  1  asynchronous, active-low reset
Clear  input  1  synchronous clear; same effect as reset, except it does not act asynchronously
PulseIn  input  1  strobe; each cycle sampled high is one event
Period  output  CNT_W  last measured interval in cycles
SpeedCode  output  2  decoded speed class of last matched interval
Valid  output  1  one-cycle pulse when Period/SpeedCode update
Mismatch  output  1  last interval matched no class
Locked  output  1  two consecutive intervals decoded to the same class
Timeout  output  1  no event for longer than the 4 s limit

Behaviour:
- Reset (Reset=0, async) or Clear=1 (sync) forces all outputs and state to 0; state goes to IDLE.
- Events:
  - Event = PulseIn==1 in a cycle, sampled at the clock edge; no edge detection.
  - PulseIn held high continuously gives a new event every cycle, i.e. interval 1.
- Interval definition: events at cycles t1 and t2 give interval t2-t1.
- Counter: loads 1 on each event, otherwise increments.
- States:
  - IDLE: counter held at 0. The first event loads counter=1 and moves to RUN. No Valid is produced.
  - RUN, event in a cycle: interval = counter value before load. Classify it, and register Period, SpeedCode, Mismatch, Locked with Valid=1 in the next cycle.
  - RUN, counter reaches LIMIT = 4F + (4F>>TOL_SHIFT) + 1 with no event: Timeout<=1, Locked<=0, go to IDLE, Period/SpeedCode hold their values.
  - Timeout clears on the next event. That event re-enters RUN as a first event and produces no Valid.
- Classification:
  - Class k matches if |P-Nk| <= Nk>>TOL_SHIFT. Use unsigned compare on CNT_W+1-bit values; no wrap.
  - Class 0 requires P==1 exactly.
  - Classes are checked in order 0,1,2,3; first hit wins. Ranges must not overlap for legal parameters.
  - No match: Mismatch=1, SpeedCode holds its previous value, Period still updates, Locked<=0.
- Locked:
  - Set when the current match class equals the class of the previous matched interval.
  - Cleared on Mismatch, timeout, reset or Clear.
- Latency: event cycle to Valid = 1 cycle. Valid is never high for 2 consecutive cycles, except in class 0, where Valid is high every cycle.
- Simultaneous cases:
  - Event in the same cycle as counter==LIMIT: the event wins; classify (result is Mismatch) and stay in RUN.
  - Clear together with an event: Clear wins.
- Reset mid-interval discards the partial count.
- Nominal interval is Nk, not Nk+1. A divider reload off-by-one is absorbed by the tolerance for k>=1.

Optional Feature:
- Macro RATE_METER_MINMAX_EN.
- Defined:
  - Adds outputs MinPeriod and MaxPeriod (CNT_W each).
  - Both are updated with every Valid interval, including Mismatch intervals.
  - The first interval after reset/Clear/timeout loads both.
  - Reset/Clear set MinPeriod to all-ones and MaxPeriod to 0. Timeout leaves them unchanged.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan (CLOCK_FREQUENCY=16, TOL_SHIFT=3, so LIMIT=73):
- Reset low then high, PulseIn held 1 for 10 cycles -> Valid every cycle from the 2nd event on, Period=1, SpeedCode=00. Locked=1 from the 2nd Valid. Mismatch=0.
- Strobes every 16 cycles, then 17, then 14 -> Period=16,17,14, all SpeedCode=01, Locked=1 after the 2nd interval.
- Strobes every 64 cycles, then one gap of 40 -> SpeedCode=11 twice, then 40 gives Mismatch=1, SpeedCode stays 11, Locked=0.
- One strobe then none for 80 cycles -> Timeout=1 at counter 73, Valid never pulses. The next strobe clears Timeout with no Valid. A strobe 32 cycles later gives Period=32, SpeedCode=10.
- Reset asserted 20 cycles into a 32-cycle interval -> all outputs 0 immediately (async). The next strobe produces no Valid.
- With RATE_METER_MINMAX_EN, intervals 16, 30, 64 -> MinPeriod=16, MaxPeriod=64. Clear -> MinPeriod=all-ones, MaxPeriod=0.
